// File: rtl/capture_fifo_pkg.sv
// Shared types and constants for the ADC capture buffer.
// State encoding matches the value driven on the state output.
package capture_fifo_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/capture_fifo_ram.sv
// Simple dual-port frame store: one write port and one registered read port.
// The read register updates only on re, so read data holds between reads.
module capture_fifo_ram
  import capture_fifo_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/capture_fifo_ctrl.sv
// Single-clock fill/freeze/drain capture buffer for ADC frames.
// Optional dropped-sample counter: define CAPTURE_DROP_CNT_EN.
module capture_fifo_ctrl
  import capture_fifo_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10,
  parameter int AFULL_LVL  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  arm,
  input  logic                  mode_cont,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  frame_done,
  output logic [1:0]            state,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [DEPTH_LOG2:0] DEPTH_L =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AFULL_L =
    AFULL_LVL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE =
    {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE =
    {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  almost_full_q, almost_full_d;
  logic                  wr_en, rd_acc;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    wr_en        = 1'b0;
    rd_acc       = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          level_d  = level_q + LVL_ONE;
          if (level_q == DEPTH_L - LVL_ONE) begin
            state_d      = ST_HOLD;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_HOLD, ST_DRAIN: begin
        if (rd_en && level_q != '0) begin
          rd_acc   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          level_d  = level_q - LVL_ONE;
          state_d  = ST_DRAIN;
          // Last word of the frame decides re-arm.
          if (level_q == LVL_ONE) begin
            state_d = mode_cont ? ST_FILL : ST_IDLE;
          end
        end
      end
      default: ;
    endcase
    out_valid_d   = rd_acc;
    almost_full_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      frame_done_q  <= frame_done_d;
      almost_full_q <= almost_full_d;
    end
  end

  capture_fifo_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en & ~rst),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

`ifdef CAPTURE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    unique case (1'b1)
      (arm && state_q == ST_IDLE):
        drop_d = '0;
      (in_valid && state_q != ST_FILL && drop_q != '1):
        drop_d = drop_q + DROP_CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign almost_full = almost_full_q;
  assign level       = level_q;
  assign full        = (level_q == DEPTH_L);
  assign empty       = (level_q == '0);
  assign state       = state_q;

endmodule

// File: tb/tb_capture_fifo_ctrl.sv
// Randomized bench for capture_fifo_ctrl against a queue-based frame model.
// Read data is checked by a scoreboard monitor on out_valid.
module tb_capture_fifo_ctrl;

  localparam int DW    = 12;
  localparam int DL    = 4;
  localparam int AF    = 12;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, arm, mode_cont, rd_en;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, full, empty, almost_full, frame_done;
  logic [DL:0]   level;
  logic [1:0]    state;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  capture_fifo_ctrl #(
    .DATA_W(DW), .DEPTH_LOG2(DL), .AFULL_LVL(AF)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .arm(arm),
    .mode_cont(mode_cont), .rd_en(rd_en),
    .out_data(out_data), .out_valid(out_valid),
    .level(level), .full(full), .empty(empty),
    .almost_full(almost_full),
    .frame_done(frame_done), .state(state),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Model: the stored frame is just a queue of words.
  int            m_st;
  logic [DW-1:0] m_buf[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ov, m_fd;
  int            m_drop;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int st0;
    st0 = m_st;
    m_ov = 0;
    m_fd = 0;
    if (rst) begin
      m_st = 0;
      m_buf.delete();
      m_drop = 0;
      return;
    end
    case (st0)
      0: if (arm) m_st = 1;
      1: if (in_valid) begin
        m_buf.push_back(in_data);
        if (m_buf.size() == DEPTH) begin
          m_st = 2;
          m_fd = 1;
        end
      end
      default: if (rd_en && m_buf.size() > 0) begin
        exp_q.push_back(m_buf.pop_front());
        m_ov = 1;
        if (m_buf.size() == 0) m_st = mode_cont ? 1 : 0;
        else m_st = 3;
      end
    endcase
`ifdef CAPTURE_DROP_CNT_EN
    if (st0 == 0 && arm) m_drop = 0;
    else if (in_valid && st0 != 1 && m_drop < 65535)
      m_drop++;
`endif
  endtask

  task automatic cyc(input bit r, input bit a,
                     input bit v, input logic [DW-1:0] d,
                     input bit rd, input bit mc);
    rst = r; arm = a; in_valid = v;
    in_data = d; rd_en = rd; mode_cont = mc;
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("level", 32'(level), 32'(m_buf.size()));
    chk("full", 32'(full), 32'(m_buf.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_buf.size() == 0));
    chk("almost_full", 32'(almost_full),
        32'(m_buf.size() >= AF));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (r) chk("rst_out_data", 32'(out_data), 32'd0);
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base,
                      input bit seq, input bit mc);
    int k;
    bit v;
    k = 0;
    while (k < n) begin
      v = ($urandom_range(0, 3) != 0);
      cyc(0, 0, v, seq ? base + DW'(k) : DW'($urandom), 0, mc);
      if (v) k++;
    end
  endtask

  task automatic drain(input int n, input bit gaps, input bit mc);
    int k;
    bit rd;
    k = 0;
    while (k < n) begin
      rd = !gaps || ($urandom_range(0, 2) != 0);
      cyc(0, 0, 0, '0, rd, mc);
      if (rd) k++;
    end
  endtask

  // Scoreboard monitor: every out_valid must match a queued read.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got %0h want none t=%0t",
                 out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    m_st = 0; m_drop = 0;
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 1, 0, '0, 0, 0);
    repeat (3) cyc(0, 0, 1, 12'h0AA, 1, 0);
    cyc(0, 1, 0, '0, 0, 0);
    fill(DEPTH, 12'h001, 1, 0);
    repeat (5) cyc(0, 0, 1, 12'h3C3, 0, 0);
    drain(DEPTH, 0, 0);
    repeat (3) cyc(0, 0, 0, '0, 1, 0);
    repeat (3) cyc(0, 0, 1, 12'h055, 0, 0);
    cyc(0, 1, 0, '0, 0, 1);
    fill(DEPTH, '0, 0, 1);
    drain(DEPTH, 1, 1);
    fill(DEPTH, 12'h100, 1, 1);
    drain(DEPTH, 1, 0);
    cyc(0, 1, 0, '0, 0, 0);
    fill(7, 12'h0F0, 1, 0);
    cyc(1, 0, 1, 12'h777, 0, 0);
    cyc(0, 1, 0, '0, 0, 0);
    fill(DEPTH, 12'h200, 1, 0);
    drain(DEPTH, 1, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, DW'($urandom),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end
    repeat (3) cyc(0, 0, 0, '0, 0, 0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
